// File: rtl/note_seq_pkg.sv
// Shared types and defaults for the note record/playback sequencer.
//   seq_state_t    : sequencer state encoding
//   CNT_W_DEF      : default width of the note counters
//   MAX_NOTES_DEF  : default number of storable notes
//   NOTE_TICKS_DEF : default clk cycles per played note (0.25 s @ 50 MHz)
//   NOTE_TIMER_W   : timer width needed for NOTE_TICKS_DEF
package note_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REC_STORE = 2'd1,
    ST_PLAY_LOAD = 2'd2,
    ST_PLAY_HOLD = 2'd3
  } seq_state_t;

  localparam int CNT_W_DEF      = 4;
  localparam int MAX_NOTES_DEF  = 15;
  localparam int NOTE_TICKS_DEF = 12_500_000;
  localparam int NOTE_TIMER_W   = $clog2(NOTE_TICKS_DEF);

endpackage

// File: rtl/note_tick_timer.sv
// Note duration timer. Counts 0..TICKS-1 while enabled and flags the last
// count so the sequencer can advance exactly TICKS cycles after it started.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-low reset
//   clear  in  restart the count at 0
//   enable in  advance the count
//   done   out enabled and at terminal count (TICKS-1)
module note_tick_timer
  import note_seq_pkg::*;
#(
  parameter int TICKS = NOTE_TICKS_DEF,
  parameter int W     = NOTE_TIMER_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] count;

  assign done = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer for the note-memory datapath. Converts key edges
// into datapath strobes, keeps the recorded-note count and the playback note
// counter, and times each played note with note_tick_timer.
// Build option: define LOOP_PLAY_EN to repeat playback until stop/reset.
// Ports:
//   clk, reset (sync, active-low)
//   record_key, play_key, stop_key, clear_key : active-high key levels
//   ld_note        : 1-cycle write strobe to the datapath
//   ld_play        : high for the whole playback
//   next_note_en   : 1-cycle pulse at the start of each played note
//   display_note   : high while a played note is sounding
//   note_counter   : current played note (1-based), 0 when not playing
//   notes_recorded : number of stored notes
//   full           : notes_recorded == MAX_NOTES
module note_seq_ctrl
  import note_seq_pkg::*;
#(
  parameter int NOTE_TICKS = NOTE_TICKS_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_NOTES  = MAX_NOTES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             record_key,
  input  logic             play_key,
  input  logic             stop_key,
  input  logic             clear_key,
  output logic             ld_note,
  output logic             ld_play,
  output logic             next_note_en,
  output logic             display_note,
  output logic [CNT_W-1:0] note_counter,
  output logic [CNT_W-1:0] notes_recorded,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NOTES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Input stage: p0 is the registered key, p1 its previous value
  logic rec_p0, rec_p1, play_p0, play_p1, clr_p0, clr_p1, stop_p0;
  logic rec_edge, play_edge, clr_edge;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rec_p0  <= 1'b0;
      rec_p1  <= 1'b0;
      play_p0 <= 1'b0;
      play_p1 <= 1'b0;
      clr_p0  <= 1'b0;
      clr_p1  <= 1'b0;
      stop_p0 <= 1'b0;
    end else begin
      rec_p0  <= record_key;
      rec_p1  <= rec_p0;
      play_p0 <= play_key;
      play_p1 <= play_p0;
      clr_p0  <= clear_key;
      clr_p1  <= clr_p0;
      stop_p0 <= stop_key;
    end
  end

  assign rec_edge  = rec_p0 & ~rec_p1;
  assign play_edge = play_p0 & ~play_p1;
  assign clr_edge  = clr_p0 & ~clr_p1;

  // Sequencer: next state and next counter values
  seq_state_t       state, state_nx;
  logic [CNT_W-1:0] note_cnt_nx, rec_cnt_nx;
  logic             tick_done;

  note_tick_timer #(
    .TICKS (NOTE_TICKS),
    .W     ($clog2(NOTE_TICKS))
  ) u_tick_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_PLAY_LOAD),
    .enable (state == ST_PLAY_HOLD),
    .done   (tick_done)
  );

  always_comb begin
    state_nx    = state;
    note_cnt_nx = note_counter;
    rec_cnt_nx  = notes_recorded;
    unique case (state)
      ST_IDLE: begin
        if (rec_edge && !full) begin
          state_nx = ST_REC_STORE;
        end else if (play_edge && (notes_recorded != '0)) begin
          state_nx    = ST_PLAY_LOAD;
          note_cnt_nx = ONE;
        end else if (clr_edge) begin
          rec_cnt_nx = '0;
        end
      end
      ST_REC_STORE: begin
        // Count moves after the ld_note cycle so the datapath writes at the old index
        state_nx = ST_IDLE;
        if (notes_recorded != MAX_CNT) rec_cnt_nx = notes_recorded + ONE;
      end
      ST_PLAY_LOAD: begin
        state_nx = ST_PLAY_HOLD;
      end
      ST_PLAY_HOLD: begin
        if (tick_done) begin
          if (note_counter < notes_recorded) begin
            state_nx    = ST_PLAY_LOAD;
            note_cnt_nx = note_counter + ONE;
          end else begin
`ifdef LOOP_PLAY_EN
            state_nx    = ST_PLAY_LOAD;
            note_cnt_nx = ONE;
`else
            state_nx    = ST_IDLE;
            note_cnt_nx = '0;
`endif
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // Stop overrides every edge, including a pending clear or count update
    if (stop_p0) begin
      state_nx    = ST_IDLE;
      note_cnt_nx = '0;
      rec_cnt_nx  = notes_recorded;
    end
  end

  // Output stage: strobes decoded from the next state and registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      ld_note        <= 1'b0;
      ld_play        <= 1'b0;
      next_note_en   <= 1'b0;
      display_note   <= 1'b0;
      note_counter   <= '0;
      notes_recorded <= '0;
      full           <= 1'b0;
    end else begin
      state          <= state_nx;
      ld_note        <= (state_nx == ST_REC_STORE);
      ld_play        <= (state_nx == ST_PLAY_LOAD) || (state_nx == ST_PLAY_HOLD);
      next_note_en   <= (state_nx == ST_PLAY_LOAD);
      display_note   <= (state_nx == ST_PLAY_HOLD);
      note_counter   <= note_cnt_nx;
      notes_recorded <= rec_cnt_nx;
      full           <= (rec_cnt_nx == MAX_CNT);
    end
  end

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Bench for note_seq_ctrl with NOTE_TICKS=4. Key presses are applied as
// operations (record, clear, play with optional stop/reset/record-during-play)
// chosen at random after a directed prelude. Expected outputs come from a
// note-count model and the playback timeline: a key driven after edge k is
// seen at edge k+1 and reflected on the registered outputs after edge k+2.
`timescale 1ns/1ps
module tb_note_seq_ctrl;

  localparam int TICKS = 4;
  localparam int CNT_W = 4;
  localparam int MAXN  = 15;
  localparam int PER   = TICKS + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic record_key = 1'b0, play_key = 1'b0, stop_key = 1'b0, clear_key = 1'b0;
  logic ld_note, ld_play, next_note_en, display_note, full;
  logic [CNT_W-1:0] note_counter, notes_recorded;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  note_seq_ctrl #(
    .NOTE_TICKS (TICKS),
    .CNT_W      (CNT_W),
    .MAX_NOTES  (MAXN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .record_key     (record_key),
    .play_key       (play_key),
    .stop_key       (stop_key),
    .clear_key      (clear_key),
    .ld_note        (ld_note),
    .ld_play        (ld_play),
    .next_note_en   (next_note_en),
    .display_note   (display_note),
    .note_counter   (note_counter),
    .notes_recorded (notes_recorded),
    .full           (full)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int ldn, input int ldp, input int nne,
                         input int disp, input int nc, input int nr);
    chk({tag, ".ld_note"},        int'(ld_note),        ldn);
    chk({tag, ".ld_play"},        int'(ld_play),        ldp);
    chk({tag, ".next_note_en"},   int'(next_note_en),   nne);
    chk({tag, ".display_note"},   int'(display_note),   disp);
    chk({tag, ".note_counter"},   int'(note_counter),   nc);
    chk({tag, ".notes_recorded"}, int'(notes_recorded), nr);
    chk({tag, ".full"},           int'(full),           int'(nr == MAXN));
  endtask

  task automatic op_rec();
    int nx;
    int pulse;
    pulse = (model_cnt < MAXN) ? 1 : 0;
    nx    = model_cnt + pulse;
    record_key = 1'b1;
    tick();
    chk_all("rec_c1", 0, 0, 0, 0, 0, model_cnt);
    record_key = 1'b0;
    tick();
    chk_all("rec_c2", pulse, 0, 0, 0, 0, model_cnt);
    tick();
    chk_all("rec_c3", 0, 0, 0, 0, 0, nx);
    model_cnt = nx;
  endtask

  task automatic op_clear();
    clear_key = 1'b1;
    tick();
    chk_all("clr_c1", 0, 0, 0, 0, 0, model_cnt);
    clear_key = 1'b0;
    tick();
    chk_all("clr_c2", 0, 0, 0, 0, 0, 0);
    model_cnt = 0;
  endtask

  // stop_d / rst_d: cycle after which stop (held 2 cycles) or reset (1 cycle)
  // is driven, -1 for none. use_rec pulses record mid-playback.
  task automatic op_play(input int stop_d_in, input int rst_d, input bit use_rec);
    int n, len, act_end, rd, end_c, k, stop_d;
    bit active, loop_b;
    int e_nne, e_disp, e_ldp, e_nc, e_nr;
    n      = model_cnt;
    len    = PER * n;
    stop_d = stop_d_in;
`ifdef LOOP_PLAY_EN
    loop_b = 1'b1;
    if (n != 0 && stop_d < 0 && rst_d < 0) stop_d = $urandom_range(2, 3 * len);
`else
    loop_b = 1'b0;
`endif
    act_end = loop_b ? (1 << 30) : 2 + len;
    if (stop_d >= 0 && stop_d + 2 < act_end) act_end = stop_d + 2;
    if (rst_d >= 0 && rst_d + 1 < act_end) act_end = rst_d + 1;
    rd = -10;
    if (use_rec && len >= 4) begin
      rd = $urandom_range(2, len - 2);
      if (rd + 1 >= act_end) rd = -10;
    end
    end_c = (n == 0) ? 2 : (loop_b ? act_end : 2 + len);
    if (stop_d >= 0 && stop_d + 3 > end_c) end_c = stop_d + 3;
    if (rst_d >= 0 && rst_d + 2 > end_c) end_c = rst_d + 2;
    end_c = end_c + 6;

    play_key = 1'b1;
    for (int c = 1; c <= end_c; c++) begin
      tick();
      active = (n != 0) && (c >= 2) && (c < act_end);
      k      = active ? (c - 2) / PER : 0;
      e_ldp  = active ? 1 : 0;
      e_nne  = (active && ((c - 2) % PER == 0)) ? 1 : 0;
      e_disp = (active && ((c - 2) % PER != 0)) ? 1 : 0;
      e_nc   = active ? ((loop_b ? (k % n) : k) + 1) : 0;
      e_nr   = (rst_d >= 0 && c >= rst_d + 1) ? 0 : n;
      chk_all("play", 0, e_ldp, e_nne, e_disp, e_nc, e_nr);
      if (c == 1) play_key = 1'b0;
      if (c == rd) record_key = 1'b1;
      if (c == rd + 1) record_key = 1'b0;
      if (c == stop_d) stop_key = 1'b1;
      if (c == stop_d + 2) stop_key = 1'b0;
      if (c == rst_d) reset = 1'b0;
      if (c == rst_d + 1) reset = 1'b1;
    end
    if (rst_d >= 0) model_cnt = 0;
  endtask

  initial begin
    int r, n;
    reset = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    // Record three notes, then play them back untouched
    for (int i = 0; i < 3; i++) op_rec();
    op_play(-1, -1, 1'b0);
    // Stop during note 2 (note 2 sounds from cycle 2+PER)
    op_play(2 + PER + 1, -1, 1'b0);
    // Record during playback is ignored
    op_play(-1, -1, 1'b1);
    // Reset while a note is held
    op_play(-1, 2 + PER + 2, 1'b0);
    // Play with nothing recorded
    op_play(-1, -1, 1'b0);
    // Fill to saturation: 16 record edges give 15 stores
    for (int i = 0; i < MAXN + 1; i++) op_rec();
    op_clear();
    op_rec();
    op_rec();
    op_play(-1, -1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      n = PER * model_cnt + 2;
      if (r <= 4) op_rec();
      else if (r == 8) op_clear();
      else if (r == 9) op_play(-1, $urandom_range(2, n), 1'b0);
      else op_play(($urandom_range(0, 2) == 0) ? $urandom_range(2, n + 1) : -1, -1,
                   1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
